mcs4_rom_bank: RTL

MCS4_ROM_BANK -- requirements
Module: mcs4_rom_bank

---
 rtl/mcs4_rom_bank.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mcs4_rom_bank.sv
// Bank of 4001-equivalent ROM/I-O chips on the MCS-4 nibble bus, single-clock with phase enables.
// Program memory is a synchronous RAM loadable from a host port; I/O ports follow SRC/WRR/RDR.
module mcs4_rom_bank #(
    parameter int                   N_CHIPS     = 2,
    parameter int                   CHIP_BASE   = 0,
    parameter logic [4*N_CHIPS-1:0] IO_DIR_MASK = '0,
    parameter string                INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clken_1,
    input  logic                   clken_2,
    input  logic                   sync,
    input  logic                   cm_rom,
    input  logic [3:0]             dbus_in,
    output logic [3:0]             dbus_out,
    output logic                   dbus_oe,
    input  logic [4*N_CHIPS-1:0]   io_in,
    output logic [4*N_CHIPS-1:0]   io_out,
    input  logic                   prog_we,
    input  logic [11:0]            prog_addr,
    input  logic [7:0]             prog_data
);

    localparam int         MEM_BYTES = N_CHIPS * 256;
    localparam int         AW        = $clog2(MEM_BYTES);
    localparam logic [3:0] BASE      = CHIP_BASE[3:0];
    localparam logic [4:0] COUNT     = N_CHIPS[4:0];

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    // Borrow-based range test so CHIP_BASE = 0 needs no special case.
    function automatic logic in_bank(input logic [3:0] chip);
        logic [5:0] diff;
        diff = {2'b00, chip} - {2'b00, BASE};
        return !diff[5] && (diff[4:0] < COUNT);
    endfunction

    function automatic logic [AW-1:0] mem_index(input logic [3:0] chip, input logic [7:0] lo);
        logic [11:0] full;
        full = {chip - BASE, lo};
        return full[AW-1:0];
    endfunction

    logic [2:0]           phase_q;
    logic [7:0]           addr_lo_q;
    logic [7:0]           fetch_q;
    logic                 fetch_sel_q;
    logic                 io_cmd_q;
    logic                 src_valid_q;
    logic [3:0]           src_chip_q;
    logic [4*N_CHIPS-1:0] io_out_q;
    logic [7:0]           mem [MEM_BYTES];

    logic       src_hit;
    logic [3:0] src_rel;
    logic       wrr_hit;
    logic       rdr_hit;
    logic [3:0] rdr_nibble;
    logic       unused_clken_1;

    assign unused_clken_1 = clken_1;
    assign src_hit = src_valid_q && in_bank(src_chip_q);
    assign src_rel = src_chip_q - BASE;
    assign wrr_hit = io_cmd_q && (fetch_q == 8'hE2) && src_hit;
    assign rdr_hit = io_cmd_q && (fetch_q == 8'hEA) && src_hit;
    assign io_out  = io_out_q;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i] = 8'h00;
        end
    end

    // Memory has no reset so contents survive rst; read-before-write gives old byte on collision.
    always_ff @(posedge clk) begin
        if (prog_we && in_bank(prog_addr[11:8])) begin
            mem[mem_index(prog_addr[11:8], prog_addr[7:0])] <= prog_data;
        end
        if (clken_2 && (phase_q == PH_A3)) begin
            fetch_q <= in_bank(dbus_in) ? mem[mem_index(dbus_in, addr_lo_q)] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_X3;
            addr_lo_q   <= 8'h00;
            fetch_sel_q <= 1'b0;
            io_cmd_q    <= 1'b0;
            src_valid_q <= 1'b0;
            src_chip_q  <= 4'h0;
            io_out_q    <= '0;
        end else if (clken_2) begin
            if (sync) begin
                phase_q <= PH_A1;
            end else if (phase_q != PH_X3) begin
                phase_q <= phase_q + 3'd1;
            end

            case (phase_q)
                PH_A1: addr_lo_q[3:0] <= dbus_in;
                PH_A2: addr_lo_q[7:4] <= dbus_in;
                PH_A3: fetch_sel_q <= cm_rom && in_bank(dbus_in);
                PH_M2: io_cmd_q <= fetch_sel_q && cm_rom;
                PH_X2: begin
                    if (cm_rom) begin
                        src_chip_q  <= dbus_in;
                        src_valid_q <= 1'b1;
                    end
                    // WRR uses the chip selected before this edge; input bits are forced low.
                    if (wrr_hit) begin
                        for (int k = 0; k < N_CHIPS; k++) begin
                            if (src_rel == 4'(k)) begin
                                io_out_q[4*k +: 4] <= dbus_in & IO_DIR_MASK[4*k +: 4];
                            end
                        end
                    end
                end
                default: ;
            endcase

            if (sync) io_cmd_q <= 1'b0;
        end
    end

    always_comb begin
        rdr_nibble = 4'h0;
        for (int k = 0; k < N_CHIPS; k++) begin
            if (src_rel == 4'(k)) begin
                rdr_nibble = (io_in[4*k +: 4] & ~IO_DIR_MASK[4*k +: 4])
                           | (io_out_q[4*k +: 4] & IO_DIR_MASK[4*k +: 4]);
            end
        end
    end

    always_comb begin
        dbus_out = 4'h0;
        dbus_oe  = 1'b0;
        case (phase_q)
            PH_M1: begin
                if (fetch_sel_q) begin
                    dbus_out = fetch_q[7:4];
                    dbus_oe  = 1'b1;
                end
            end
            PH_M2: begin
                if (fetch_sel_q) begin
                    dbus_out = fetch_q[3:0];
                    dbus_oe  = 1'b1;
                end
            end
            PH_X2: begin
                if (rdr_hit) begin
                    dbus_out = rdr_nibble;
                    dbus_oe  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
